move_stack: RTL and testbench

Move history for the maze walker. Every forward step the walker commits is pushed with its 2-bit direction code. On backtrack a pop returns the undone direction and restores the position to the cell before that step. After a solve, the stored path plays back in forward order over a valid/ready stream, so the path can be read out from start to goal.

---
 rtl/move_stack.sv | 181 ++++++++++++++++++
 tb/tb_move_stack.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_stack.sv
// Move history for the maze walker: a push/pop stack of 2-bit direction codes that
// tracks the walker position and can replay the stored path oldest-first over valid/ready.
module move_stack #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int PW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [1:0]    dir_in,
  input  logic          pop,
  output logic          pop_valid,
  output logic [1:0]    dir_out,
  output logic [PW-1:0] row,
  output logic [PW-1:0] colomn,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          err,
  input  logic          play,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [1:0]    rd_dir,
  output logic          rd_done,
  output logic          state_dbg
);

  // rd_valid/rd_ready: an entry transfers on every rising clk edge where both are
  // high; while rd_valid is high and rd_ready low, rd_dir holds its value.

  typedef enum logic {TRACK = 1'b0, PLAY = 1'b1} state_t;

  localparam logic [AW:0]   ONE_S   = (AW+1)'(1);
  localparam logic [AW:0]   SP_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  state_t        state;
  logic [AW:0]   sp;
  logic [AW-1:0] idx;
  logic [1:0]    mem [DEPTH];

  logic [AW-1:0] top_addr;
  logic [AW-1:0] idx_nxt;
  logic [1:0]    top;
  logic          do_push, do_pop, do_repl, start_play, empty_done, req_err;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  // One move in direction d; the inverse move of d is ~d.
  function automatic logic [2*PW-1:0] mv(input logic [PW-1:0] r,
                                         input logic [PW-1:0] c,
                                         input logic [1:0]    d);
    logic [PW-1:0] nr, nc;
    nr = r;
    nc = c;
    case (d)
      2'd0: nc = c + ONE_P;
      2'd1: nr = r + ONE_P;
      2'd2: nr = r - ONE_P;
      default: nc = c - ONE_P;
    endcase
    return {nr, nc};
  endfunction

  assign top_addr  = sp[AW-1:0] - ONE_A;
  assign idx_nxt   = idx + ONE_A;
  assign top       = mem[top_addr];
  assign count     = sp;
  assign state_dbg = (state == PLAY);

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_repl    = 1'b0;
    start_play = 1'b0;
    empty_done = 1'b0;
    req_err    = 1'b0;
    if (state == TRACK) begin
      if (play && !empty) begin
        start_play = 1'b1;
        req_err    = push | pop;
      end else begin
        empty_done = play;
        if (push && pop) begin
          if (empty) begin
            do_push = 1'b1;
            req_err = 1'b1;
          end else begin
            do_repl = 1'b1;
          end
        end else if (push) begin
          if (full) req_err = 1'b1;
          else      do_push = 1'b1;
        end else if (pop) begin
          if (empty) req_err = 1'b1;
          else       do_pop  = 1'b1;
        end
      end
    end else begin
      req_err = push | pop;
    end
  end

  assign mem_we    = do_push | do_repl;
  assign mem_waddr = do_repl ? top_addr : sp[AW-1:0];

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= dir_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TRACK;
      sp        <= '0;
      idx       <= '0;
      row       <= '0;
      colomn    <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      err       <= 1'b0;
      pop_valid <= 1'b0;
      dir_out   <= 2'd0;
      rd_valid  <= 1'b0;
      rd_dir    <= 2'd0;
      rd_done   <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      rd_done   <= 1'b0;
      if (req_err) err <= 1'b1;
      case (state)
        TRACK: begin
          if (start_play) begin
            state    <= PLAY;
            idx      <= '0;
            rd_valid <= 1'b1;
            rd_dir   <= mem[0];
          end
          if (empty_done) rd_done <= 1'b1;
          if (do_push) begin
            sp              <= sp + ONE_S;
            {row, colomn}   <= mv(row, colomn, dir_in);
            empty           <= 1'b0;
            full            <= (sp == SP_LAST);
          end
          if (do_pop) begin
            sp              <= sp - ONE_S;
            dir_out         <= top;
            pop_valid       <= 1'b1;
            {row, colomn}   <= mv(row, colomn, ~top);
            empty           <= (sp == ONE_S);
            full            <= 1'b0;
          end
          if (do_repl) begin
            dir_out         <= top;
            pop_valid       <= 1'b1;
            {row, colomn}   <= mv(mv(row, colomn, ~top) >> PW,
                                  mv(row, colomn, ~top) & {{PW{1'b0}}, {PW{1'b1}}},
                                  dir_in);
          end
        end
        PLAY: begin
          if (rd_valid && rd_ready) begin
            if (idx == top_addr) begin
              rd_valid <= 1'b0;
              rd_done  <= 1'b1;
              state    <= TRACK;
            end else begin
              idx    <= idx_nxt;
              rd_dir <= mem[idx_nxt];
            end
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_move_stack.sv
// Directed bench for move_stack: position/count checks against hand-derived values,
// popped and played-back directions checked through an expected queue.
module tb_move_stack;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, play, rd_ready;
  logic [1:0]    dir_in;
  logic          pop_valid, empty, full, err, rd_valid, rd_done, state_dbg;
  logic [1:0]    dir_out, rd_dir;
  logic [PW-1:0] row, colomn;
  logic [AW:0]   count;

  logic [1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  move_stack #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .dir_in(dir_in), .pop(pop),
    .pop_valid(pop_valid), .dir_out(dir_out), .row(row), .colomn(colomn),
    .count(count), .empty(empty), .full(full), .err(err), .play(play),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dir(rd_dir),
    .rd_done(rd_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic reset_dut();
    push = 1'b0; pop = 1'b0; play = 1'b0; rd_ready = 1'b0; dir_in = 2'd0;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_one(input logic [1:0] d);
    push = 1'b1; dir_in = d;
    tick();
    push = 1'b0;
  endtask

  task automatic expect_pop(input string tag);
    logic [1:0] e;
    check({tag, "_pop_valid"}, pop_valid, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_dir_out"}, dir_out, e);
    end
  endtask

  initial begin
    logic [1:0] held;
    logic [3:0] ready_pat;

    reset_dut();
    rst_n = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_row", row, 0);
    check("rst_colomn", colomn, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_dir_out", dir_out, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_dir", rd_dir, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();

    // push 0,1,1,3 back to back
    push = 1'b1;
    dir_in = 2'd0; tick();
    dir_in = 2'd1; tick();
    dir_in = 2'd1; tick();
    dir_in = 2'd3; tick();
    push = 1'b0;
    check("p4_count", count, 4);
    check("p4_row", row, 2);
    check("p4_colomn", colomn, 0);
    check("p4_empty", empty, 0);
    check("p4_err", err, 0);

    // two back-to-back pops
    pop = 1'b1;
    exp_q.push_back(2'd3);
    tick();
    expect_pop("pop1");
    exp_q.push_back(2'd1);
    tick();
    pop = 1'b0;
    expect_pop("pop2");
    tick();
    check("pop_pulse_len", pop_valid, 0);
    check("pop_row", row, 1);
    check("pop_colomn", colomn, 1);
    check("pop_count", count, 2);

    // pop on empty, then push 2 wraps the row
    reset_dut();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("epop_err", err, 1);
    check("epop_count", count, 0);
    check("epop_no_valid", pop_valid, 0);
    push_one(2'd2);
    check("wrap_row", row, 15);
    check("wrap_colomn", colomn, 0);
    check("wrap_count", count, 1);

    // fill to DEPTH, then one extra push
    reset_dut();
    push = 1'b1; dir_in = 2'd1;
    repeat (DEPTH - 1) tick();
    check("fill255_full", full, 0);
    check("fill255_count", count, DEPTH - 1);
    tick();
    push = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, DEPTH);
    check("fill_row", row, 0);
    check("fill_err_clean", err, 0);
    push_one(2'd1);
    check("over_err", err, 1);
    check("over_count", count, DEPTH);
    check("over_row", row, 0);

    // playback with a stall
    reset_dut();
    push_one(2'd0); exp_q.push_back(2'd0);
    push_one(2'd1); exp_q.push_back(2'd1);
    push_one(2'd2); exp_q.push_back(2'd2);
    play = 1'b1;
    tick();
    play = 1'b0;
    check("pl_state", state_dbg, 1);
    ready_pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      rd_ready = ready_pat[i];
      check("pl_rd_valid", rd_valid, 1);
      check("pl_no_done", rd_done, 0);
      held = rd_dir;
      if (rd_ready) begin
        if (exp_q.size() == 0) check("pl_queue_empty", 1, 0);
        else check("pl_rd_dir", rd_dir, exp_q.pop_front());
        tick();
      end else begin
        tick();
        check("pl_hold", rd_dir, held);
      end
    end
    rd_ready = 1'b0;
    check("pl_rd_done", rd_done, 1);
    check("pl_valid_low", rd_valid, 0);
    check("pl_count", count, 3);
    check("pl_back_track", state_dbg, 0);
    check("pl_err", err, 0);
    check("pl_all_out", exp_q.size(), 0);
    push_one(2'd3);
    check("pl_done_pulse", rd_done, 0);
    check("pl_push_after", count, 4);

    // top replace: top=1, dir_in=0
    reset_dut();
    push_one(2'd1);
    push = 1'b1; pop = 1'b1; dir_in = 2'd0;
    exp_q.push_back(2'd1);
    tick();
    push = 1'b0; pop = 1'b0;
    expect_pop("repl");
    check("repl_count", count, 1);
    check("repl_row", row, 0);
    check("repl_colomn", colomn, 1);
    check("repl_err", err, 0);

    // push during playback is refused
    play = 1'b1;
    tick();
    play = 1'b0;
    push_one(2'd2);
    check("plpush_err", err, 1);
    check("plpush_count", count, 1);

    // asynchronous reset in the middle of playback
    reset_dut();
    push_one(2'd0);
    push_one(2'd1);
    play = 1'b1;
    tick();
    play = 1'b0;
    check("mid_valid", rd_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_state", state_dbg, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // play on empty stack
    play = 1'b1;
    tick();
    play = 1'b0;
    check("eplay_done", rd_done, 1);
    check("eplay_valid", rd_valid, 0);
    check("eplay_state", state_dbg, 0);
    tick();
    check("eplay_pulse", rd_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
